// File: rtl/fmul_float_pkg.sv
// rtl/fmul_float_pkg.sv - shared rounding-mode encoding and format constants for the fmul datapath
package fmul_float_pkg;

  localparam int FRAC_W_DEF = 23;
  localparam int EXP_W_DEF  = 8;
  localparam int EXC_W_DEF  = 6;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } round_mode_t;

  // Smallest biased exponent that no longer fits a finite value (all-ones field).
  function automatic int bias_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fmul_float_normalize_round_pipe_if.sv
// rtl/fmul_float_normalize_round_pipe_if.sv - upstream/downstream bundle of the normalize/round pipe
interface fmul_float_normalize_round_pipe_if
  import fmul_float_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int EXC_W  = EXC_W_DEF
);
  localparam int PROD_W = 2 * (FRAC_W + 1);

  logic                iDATA_VALID;
  logic                oDATA_BUSY;
  logic                iDATA_SIGN;
  logic [EXP_W+1:0]    iDATA_EXP;
  logic [PROD_W-1:0]   iDATA_FRACT;
  logic [EXC_W-1:0]    iDATA_EXCEPT;
  logic [2:0]          iROUND_MODE;
  logic                oDATA_VALID;
  logic                iDATA_BUSY;
  logic                oDATA_SIGN;
  logic [EXP_W+1:0]    oDATA_EXP;
  logic [FRAC_W:0]     oDATA_FRACT;
  logic [EXC_W-1:0]    oDATA_EXCEPT;
  logic                oDATA_INEXACT;
  logic                oDATA_OVF;
  logic                oDATA_UNF;

  modport master (
    output iDATA_VALID, iDATA_SIGN, iDATA_EXP, iDATA_FRACT, iDATA_EXCEPT, iROUND_MODE, iDATA_BUSY,
    input  oDATA_BUSY, oDATA_VALID, oDATA_SIGN, oDATA_EXP, oDATA_FRACT, oDATA_EXCEPT,
           oDATA_INEXACT, oDATA_OVF, oDATA_UNF
  );

  modport slave (
    input  iDATA_VALID, iDATA_SIGN, iDATA_EXP, iDATA_FRACT, iDATA_EXCEPT, iROUND_MODE, iDATA_BUSY,
    output oDATA_BUSY, oDATA_VALID, oDATA_SIGN, oDATA_EXP, oDATA_FRACT, oDATA_EXCEPT,
           oDATA_INEXACT, oDATA_OVF, oDATA_UNF
  );

endinterface

// File: rtl/fmul_float_round_inc.sv
// rtl/fmul_float_round_inc.sv - IEEE-754 rounding-increment decision from sign, LSB, guard and sticky
module fmul_float_round_inc
  import fmul_float_pkg::*;
(
  input  logic [2:0] i_mode,
  input  logic       i_sign,
  input  logic       i_lsb,
  input  logic       i_guard,
  input  logic       i_sticky,
  output logic       o_inc,
  output logic       o_inexact
);

  logic w_gs;

  assign w_gs      = i_guard | i_sticky;
  assign o_inexact = w_gs;

  // Unused encodings fall back to round-to-nearest-even.
  always_comb begin
    o_inc = i_guard & (i_lsb | i_sticky);
    case (i_mode)
      RM_RTZ:  o_inc = 1'b0;
      RM_RDN:  o_inc = i_sign & w_gs;
      RM_RUP:  o_inc = ~i_sign & w_gs;
      RM_RMM:  o_inc = i_guard;
      default: o_inc = i_guard & (i_lsb | i_sticky);
    endcase
  end

endmodule

// File: rtl/fmul_float_normalize_round_pipe.sv
// rtl/fmul_float_normalize_round_pipe.sv - two-stage normalize/round of the fmul significand product
module fmul_float_normalize_round_pipe
  import fmul_float_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int EXC_W  = EXC_W_DEF
) (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic iRESET_SYNC,
  fmul_float_normalize_round_pipe_if.slave bus
);

  localparam int PROD_W = 2 * (FRAC_W + 1);
  localparam int XW     = EXP_W + 2;
  localparam logic signed [XW-1:0] L_OVF_EXP = XW'(bias_max(EXP_W));

  logic              w_s2_hold;
  logic              w_s1_hold;
  logic              w_accept;
  logic              w_msb;
  logic [FRAC_W:0]   w_mant;
  logic              w_guard;
  logic              w_sticky;
  logic [XW-1:0]     w_exp1;
  logic              w_inc;
  logic              w_inexact;

  logic              r_s1_valid;
  logic              r_s1_sign;
  logic [XW-1:0]     r_s1_exp;
  logic [FRAC_W:0]   r_s1_mant;
  logic              r_s1_inc;
  logic              r_s1_inexact;
  logic [EXC_W-1:0]  r_s1_except;

  logic [FRAC_W+1:0] w_sum;
  logic              w_carry;
  logic [FRAC_W:0]   w_fract2;
  logic [XW-1:0]     w_exp2;
  logic              w_ovf;
  logic              w_unf;

  logic              r_s2_valid;
  logic              r_s2_sign;
  logic [XW-1:0]     r_s2_exp;
  logic [FRAC_W:0]   r_s2_fract;
  logic [EXC_W-1:0]  r_s2_except;
  logic              r_s2_inexact;
  logic              r_s2_ovf;
  logic              r_s2_unf;

  // A stage stalls only when it holds data that cannot move on.
  assign w_s2_hold      = r_s2_valid & bus.iDATA_BUSY;
  assign w_s1_hold      = r_s1_valid & w_s2_hold;
  assign w_accept       = bus.iDATA_VALID & ~w_s1_hold;
  assign bus.oDATA_BUSY = w_s1_hold;

  assign w_msb    = bus.iDATA_FRACT[PROD_W-1];
  assign w_mant   = w_msb ? bus.iDATA_FRACT[PROD_W-1:FRAC_W+1] : bus.iDATA_FRACT[PROD_W-2:FRAC_W];
  assign w_guard  = w_msb ? bus.iDATA_FRACT[FRAC_W] : bus.iDATA_FRACT[FRAC_W-1];
  assign w_sticky = w_msb ? |bus.iDATA_FRACT[FRAC_W-1:0] : |bus.iDATA_FRACT[FRAC_W-2:0];
  assign w_exp1   = bus.iDATA_EXP + XW'(w_msb);

  fmul_float_round_inc u_round_inc (
    .i_mode    (bus.iROUND_MODE),
    .i_sign    (bus.iDATA_SIGN),
    .i_lsb     (w_mant[0]),
    .i_guard   (w_guard),
    .i_sticky  (w_sticky),
    .o_inc     (w_inc),
    .o_inexact (w_inexact)
  );

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_s1_valid   <= 1'b0;
      r_s1_sign    <= 1'b0;
      r_s1_exp     <= '0;
      r_s1_mant    <= '0;
      r_s1_inc     <= 1'b0;
      r_s1_inexact <= 1'b0;
      r_s1_except  <= '0;
    end else if (iRESET_SYNC) begin
      r_s1_valid   <= 1'b0;
      r_s1_sign    <= 1'b0;
      r_s1_exp     <= '0;
      r_s1_mant    <= '0;
      r_s1_inc     <= 1'b0;
      r_s1_inexact <= 1'b0;
      r_s1_except  <= '0;
    end else if (!w_s1_hold) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sign    <= bus.iDATA_SIGN;
        r_s1_exp     <= w_exp1;
        r_s1_mant    <= w_mant;
        r_s1_inc     <= w_inc;
        r_s1_inexact <= w_inexact;
        r_s1_except  <= bus.iDATA_EXCEPT;
      end
    end
  end

  // An all-ones mantissa rounding up carries out; the result is exactly 1.0 at exponent+1.
  assign w_sum    = {1'b0, r_s1_mant} + (FRAC_W+2)'(r_s1_inc);
  assign w_carry  = w_sum[FRAC_W+1];
  assign w_fract2 = w_carry ? {1'b1, {FRAC_W{1'b0}}} : w_sum[FRAC_W:0];
  assign w_exp2   = r_s1_exp + XW'(w_carry);
  assign w_ovf    = $signed(w_exp2) >= L_OVF_EXP;
  assign w_unf    = w_exp2[XW-1] | (w_exp2 == '0);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_s2_valid   <= 1'b0;
      r_s2_sign    <= 1'b0;
      r_s2_exp     <= '0;
      r_s2_fract   <= '0;
      r_s2_except  <= '0;
      r_s2_inexact <= 1'b0;
      r_s2_ovf     <= 1'b0;
      r_s2_unf     <= 1'b0;
    end else if (iRESET_SYNC) begin
      r_s2_valid   <= 1'b0;
      r_s2_sign    <= 1'b0;
      r_s2_exp     <= '0;
      r_s2_fract   <= '0;
      r_s2_except  <= '0;
      r_s2_inexact <= 1'b0;
      r_s2_ovf     <= 1'b0;
      r_s2_unf     <= 1'b0;
    end else if (!w_s2_hold) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sign    <= r_s1_sign;
        r_s2_exp     <= w_exp2;
        r_s2_fract   <= w_fract2;
        r_s2_except  <= r_s1_except;
        r_s2_inexact <= r_s1_inexact;
        r_s2_ovf     <= w_ovf;
        r_s2_unf     <= w_unf;
      end
    end
  end

  assign bus.oDATA_VALID   = r_s2_valid;
  assign bus.oDATA_SIGN    = r_s2_sign;
  assign bus.oDATA_EXP     = r_s2_exp;
  assign bus.oDATA_FRACT   = r_s2_fract;
  assign bus.oDATA_EXCEPT  = r_s2_except;
  assign bus.oDATA_INEXACT = r_s2_inexact;
  assign bus.oDATA_OVF     = r_s2_ovf;
  assign bus.oDATA_UNF     = r_s2_unf;

endmodule

// File: tb/tb_fmul_float_normalize_round_pipe.sv
// tb/tb_fmul_float_normalize_round_pipe.sv - scoreboard bench for the fmul normalize/round pipe
module tb_fmul_float_normalize_round_pipe;

  typedef struct {
    bit         sign;
    logic [2:0] mode;
    logic [9:0] exp;
    logic [47:0] fract;
    logic [5:0] exc;
  } op_t;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] fract;
    logic [5:0]  exc;
    logic        inexact;
    logic        ovf;
    logic        unf;
  } res_t;

  logic clk;
  logic rst_n;
  logic rst_sync;
  int   checks;
  int   failures;
  bit   bp_force;
  bit   bp_rand;
  res_t sb[$];

  fmul_float_normalize_round_pipe_if #(.FRAC_W(23), .EXP_W(8), .EXC_W(6)) bus ();

  fmul_float_normalize_round_pipe #(.FRAC_W(23), .EXP_W(8), .EXC_W(6)) dut (
    .iCLOCK      (clk),
    .inRESET     (rst_n),
    .iRESET_SYNC (rst_sync),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) bus.iDATA_BUSY <= bp_force | (bp_rand && ($urandom_range(0, 2) == 0));

  // Reference: round the exact product by comparing the discarded remainder with one half.
  function automatic res_t model(input op_t op);
    res_t r;
    longint unsigned pv, mant, rem, half;
    int sh, e;
    bit inc;
    logic [9:0] e10;
    pv   = 64'(op.fract);
    sh   = op.fract[47] ? 24 : 23;
    mant = pv >> sh;
    rem  = pv - (mant << sh);
    half = 64'd1 << (sh - 1);
    case (op.mode)
      3'd1:    inc = 1'b0;
      3'd2:    inc = op.sign && (rem != 0);
      3'd3:    inc = !op.sign && (rem != 0);
      3'd4:    inc = (rem >= half);
      default: inc = (rem > half) || ((rem == half) && mant[0]);
    endcase
    mant = mant + 64'(inc);
    e = int'($signed(op.exp)) + (op.fract[47] ? 1 : 0);
    if (mant == (64'd1 << 24)) begin
      mant = 64'd1 << 23;
      e++;
    end
    e10       = e[9:0];
    r.sign    = op.sign;
    r.exp     = e10;
    r.fract   = mant[23:0];
    r.exc     = op.exc;
    r.inexact = (rem != 0);
    r.ovf     = ($signed(e10) >= 10'sd255);
    r.unf     = ($signed(e10) <= 10'sd0);
    return r;
  endfunction

  function automatic res_t get_out();
    res_t r;
    r.sign    = bus.oDATA_SIGN;
    r.exp     = bus.oDATA_EXP;
    r.fract   = bus.oDATA_FRACT;
    r.exc     = bus.oDATA_EXCEPT;
    r.inexact = bus.oDATA_INEXACT;
    r.ovf     = bus.oDATA_OVF;
    r.unf     = bus.oDATA_UNF;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Must be called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input op_t op);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    bus.iDATA_SIGN   = op.sign;
    bus.iROUND_MODE  = op.mode;
    bus.iDATA_EXP    = op.exp;
    bus.iDATA_FRACT  = op.fract;
    bus.iDATA_EXCEPT = op.exc;
    bus.iDATA_VALID  = 1'b1;
    while (!acc && n < 500) begin
      #4;
      if (!bus.oDATA_BUSY) begin
        acc = 1'b1;
        sb.push_back(model(op));
      end
      @(negedge clk);
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=busy required=accepted");
    end
    bus.iDATA_VALID = 1'b0;
  endtask

  task automatic directed(input bit sign, input logic [2:0] mode, input logic [9:0] exp,
                          input logic [47:0] fract, input logic [23:0] x_fract,
                          input logic [9:0] x_exp, input logic [2:0] x_flags);
    op_t op;
    res_t m;
    op.sign = sign; op.mode = mode; op.exp = exp; op.fract = fract;
    op.exc = 6'($urandom_range(0, 63));
    m = model(op);
    check("plan_vector", 64'({m.fract, m.exp, m.inexact, m.ovf, m.unf}),
          64'({x_fract, x_exp, x_flags}));
    send(op);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({bus.oDATA_VALID, bus.oDATA_BUSY, get_out()}), 64'd0);
  endtask

  // Monitor: looks just before each rising edge, when a downstream transfer is decided.
  res_t prev_out;
  bit   prev_hold;
  always begin
    res_t cur, e;
    @(negedge clk);
    #4;
    if (!rst_n || rst_sync) begin
      prev_hold = 1'b0;
    end else begin
      cur = get_out();
      if (prev_hold) check("held_stable", 64'(cur), 64'(prev_out));
      prev_hold = bus.oDATA_VALID && bus.iDATA_BUSY;
      prev_out  = cur;
      if (bus.oDATA_VALID && !bus.iDATA_BUSY) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", cur);
        end else begin
          e = sb.pop_front();
          check("result", 64'(cur), 64'(e));
        end
      end
    end
  end

  initial begin
    op_t op;
    logic [63:0] r64;
    checks = 0; failures = 0;
    bp_force = 1'b0; bp_rand = 1'b0;
    rst_sync = 1'b0; rst_n = 1'b1;
    bus.iDATA_VALID = 1'b0; bus.iDATA_SIGN = 1'b0; bus.iDATA_EXP = '0;
    bus.iDATA_FRACT = '0; bus.iDATA_EXCEPT = '0; bus.iROUND_MODE = '0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_state");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    directed(0, 3'd0, 10'd127, 48'h4000_0000_0000, 24'h800000, 10'd127, 3'b000);
    directed(0, 3'd0, 10'd127, 48'h8000_0000_0000, 24'h800000, 10'd128, 3'b000);
    directed(0, 3'd0, 10'd127, 48'h4000_0040_0000, 24'h800000, 10'd127, 3'b100);
    directed(0, 3'd0, 10'd127, 48'h4000_00C0_0000, 24'h800002, 10'd127, 3'b100);
    directed(0, 3'd0, 10'd127, 48'h7FFF_FFC0_0000, 24'h800000, 10'd128, 3'b100);
    directed(0, 3'd1, 10'd127, 48'h7FFF_FFC0_0000, 24'hFFFFFF, 10'd127, 3'b100);
    directed(1, 3'd2, 10'd127, 48'h7FFF_FFC0_0000, 24'h800000, 10'd128, 3'b100);
    directed(0, 3'd4, 10'd127, 48'h4000_0040_0000, 24'h800001, 10'd127, 3'b100);
    directed(0, 3'd3, 10'd127, 48'h4000_0000_0001, 24'h800001, 10'd127, 3'b100);
    directed(1, 3'd3, 10'd127, 48'h4000_0000_0001, 24'h800000, 10'd127, 3'b100);
    directed(0, 3'd6, 10'd127, 48'h4000_00C0_0000, 24'h800002, 10'd127, 3'b100);
    directed(0, 3'd0, 10'd254, 48'h8000_0000_0000, 24'h800000, 10'd255, 3'b010);
    directed(0, 3'd0, 10'd0,   48'h4000_0000_0000, 24'h800000, 10'd0,   3'b001);
    directed(0, 3'd0, 10'h3FB, 48'h4000_0000_0000, 24'h800000, 10'h3FB, 3'b001);
    drain();

    // Backpressure: four ops against a stalled sink.
    @(posedge clk); #1 bp_force = 1'b1;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          op.sign = 1'($urandom); op.mode = 3'($urandom_range(0, 4));
          op.exp = 10'($urandom_range(1, 250)); r64 = {$urandom, $urandom};
          op.fract = {2'b01, r64[45:0]}; op.exc = 6'($urandom);
          send(op);
        end
      end
    join_none
    repeat (2) @(negedge clk);
    #4 check("busy_when_full", 64'(bus.oDATA_BUSY), 64'd1);
    @(posedge clk); #1 bp_force = 1'b0;
    wait fork;
    drain();

    // Random stream with random sink stalls and input gaps.
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r64 = {$urandom, $urandom};
      op.sign = 1'($urandom); op.mode = 3'($urandom_range(0, 7));
      op.exp = 10'($urandom); op.exc = 6'($urandom);
      op.fract = r64[47:0];
      case ($urandom_range(0, 3))
        0: op.fract[47] = 1'b1;
        1: op.fract[47:46] = 2'b01;
        2: begin op.fract[47:46] = 2'b01; op.fract[21:0] = '0; end
        default: ;
      endcase
      send(op);
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    bp_rand = 1'b0;
    drain();

    // Asynchronous reset with both stages occupied.
    @(posedge clk); #1 bp_force = 1'b1;
    @(negedge clk);
    op.sign = 1'b1; op.mode = 3'd0; op.exp = 10'd100; op.fract = 48'hC000_0000_0001; op.exc = 6'h3F;
    send(op); send(op);
    check("valid_before_reset", 64'(bus.oDATA_VALID), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_clears");
    sb.delete();
    @(negedge clk);
    #1 rst_n = 1'b1; bp_force = 1'b0;
    @(negedge clk);

    // Synchronous clear with both stages occupied.
    @(posedge clk); #1 bp_force = 1'b1;
    @(negedge clk);
    send(op); send(op);
    rst_sync = 1'b1;
    @(posedge clk);
    #1 check_all_zero("sync_reset_clears");
    rst_sync = 1'b0; bp_force = 1'b0;
    sb.delete();
    @(negedge clk);
    op.mode = 3'd1;
    send(op);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
